pipe_collision_score: RTL and testbench

//  Consumes the pipe positions from pipeA/pipeB and the bird position; detects bird-pipe
//  and bird-floor/ceiling collisions and keeps the game score. Sits downstream of the pipe

---
 rtl/pipe_collision_score.sv | 174 +++++++++++++++++
 tb/tb_pipe_collision_score.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_collision_score.sv
// Bird/pipe and bird/floor/ceiling collision detection plus BCD game scoring.
// Stage 1 registers the per-cycle hit and pass events; stage 2 runs the game FSM and score.
module pipe_collision_score #(
    parameter int unsigned BIRD_X   = 100,
    parameter int unsigned BIRD_W   = 20,
    parameter int unsigned BIRD_H   = 20,
    parameter int unsigned PIPE_W   = 50,
    parameter int unsigned GAP_H    = 120,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [9:0]  BirdPosY,
    input  logic [9:0]  PipePosXA,
    input  logic [9:0]  PipePosYA,
    input  logic [9:0]  PipePosXB,
    input  logic [9:0]  PipePosYB,
    output logic        Lost,
    output logic        Playing,
    output logic [15:0] Score,
    output logic [15:0] HighScore
);

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StPlay = 3'b010,
        StDead = 3'b100
    } state_e;

    localparam logic [10:0] BirdLeft  = 11'(BIRD_X);
    localparam logic [10:0] BirdRight = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] BirdH     = 11'(BIRD_H);
    localparam logic [10:0] PipeW     = 11'(PIPE_W);
    localparam logic [10:0] GapH      = 11'(GAP_H);
    localparam logic [10:0] ScreenH   = 11'(SCREEN_H);

    state_e      state_q, state_d;
    logic        hit_q, hit_d;
    logic [1:0]  pass_q, pass_d;
    logic [1:0]  arm_q, arm_d;
    logic [15:0] score_q, score_d;
    logic [15:0] high_q, high_d;

    // Index 1 is pipe A, index 0 is pipe B, so pass vectors read {passA, passB}.
    logic [1:0][10:0] pipe_x;
    logic [1:0][10:0] pipe_y;
    logic [10:0]      bird_top;
    logic [10:0]      bird_bot;
    logic [1:0]       hov;
    logic [1:0]       safe;
    logic [1:0]       pass_now;
    logic             boundary;
    logic             hit_now;

    assign pipe_x[1] = {1'b0, PipePosXA};
    assign pipe_y[1] = {1'b0, PipePosYA};
    assign pipe_x[0] = {1'b0, PipePosXB};
    assign pipe_y[0] = {1'b0, PipePosYB};
    assign bird_top  = {1'b0, BirdPosY};
    assign bird_bot  = bird_top + BirdH;
    assign boundary  = (BirdPosY == 10'd0) || (bird_bot >= ScreenH);

    // Stage 1 geometry: all sums kept in 11 bits so nothing wraps near the screen edges.
    always_comb begin
        hit_now = boundary;
        for (int p = 0; p < 2; p++) begin
            hov[p]      = (pipe_x[p] < BirdRight) && ((pipe_x[p] + PipeW) > BirdLeft);
            safe[p]     = (bird_top >= pipe_y[p]) && (bird_bot <= (pipe_y[p] + GapH));
            pass_now[p] = arm_q[p] && ((pipe_x[p] + PipeW) <= BirdLeft);
            hit_now     = hit_now | (hov[p] & ~safe[p]);
            // Arm clears on the counted pass and re-arms once the pipe is back right of the bird.
            if (pass_now[p]) begin
                arm_d[p] = 1'b0;
            end else if (pipe_x[p] >= BirdRight) begin
                arm_d[p] = 1'b1;
            end else begin
                arm_d[p] = arm_q[p];
            end
        end
    end

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    logic [15:0] score_one;
    logic [15:0] score_two;
    logic        flush;
    logic        end_game;

    // Stage 2: game FSM and score act on the registered events.
    always_comb begin
        score_one = pass_q[1] ? bcd_inc(score_q) : score_q;
        score_two = pass_q[0] ? bcd_inc(score_one) : score_one;
        state_d   = state_q;
        score_d   = score_q;
        high_d    = high_q;
        flush     = 1'b0;
        end_game  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StPlay;
                    score_d = '0;
                    flush   = 1'b1;
                end
            end
            StPlay: begin
                if (!Start) begin
                    state_d  = StIdle;
                    end_game = 1'b1;
                end else if (hit_q) begin
                    state_d  = StDead;
                    end_game = 1'b1;
                end else begin
                    score_d = score_two;
                end
            end
            StDead: begin
                if (!Start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // BCD digits order the same way as binary, so a plain compare picks the best score.
        if (end_game && (score_q > high_q)) begin
            high_d = score_q;
        end
        hit_d  = flush ? 1'b0 : hit_now;
        pass_d = flush ? 2'b00 : pass_now;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            hit_q   <= 1'b0;
            pass_q  <= 2'b00;
            arm_q   <= 2'b00;
            score_q <= '0;
            high_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            pass_q  <= pass_d;
            arm_q   <= arm_d;
            score_q <= score_d;
            high_q  <= high_d;
        end
    end

    assign Lost      = (state_q == StDead);
    assign Playing   = (state_q == StPlay);
    assign Score     = score_q;
    assign HighScore = high_q;

endmodule

// File: tb/tb_pipe_collision_score.sv
// Self-checking bench for pipe_collision_score: integer-level reference model checked every
// cycle, a table of collision geometry vectors, and hand-written game sequences.
module tb_pipe_collision_score;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  by = 10'd200;
    logic [9:0]  xa = 10'd1023;
    logic [9:0]  ya = 10'd150;
    logic [9:0]  xb = 10'd1023;
    logic [9:0]  yb = 10'd150;
    logic        lost;
    logic        playing;
    logic [15:0] score;
    logic [15:0] high;

    int checks = 0;
    int errors = 0;

    pipe_collision_score dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .BirdPosY  (by),
        .PipePosXA (xa),
        .PipePosYA (ya),
        .PipePosXB (xb),
        .PipePosYB (yb),
        .Lost      (lost),
        .Playing   (playing),
        .Score     (score),
        .HighScore (high)
    );

    always #5 clk = ~clk;

    // Reference model: game state 0=idle 1=play 2=dead, scores as plain integers.
    int m_state = 0;
    int m_score = 0;
    int m_high  = 0;
    bit m_arm[2] = '{0, 0};
    bit m_hit   = 0;
    int m_npass = 0;

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  xs[2];
        int  ys[2];
        int  b;
        int  np;
        bit  hit;
        bit  flush;
        xs[0] = int'(xa);
        xs[1] = int'(xb);
        ys[0] = int'(ya);
        ys[1] = int'(yb);
        b     = int'(by);
        if (rst) begin
            m_state = 0; m_score = 0; m_high = 0;
            m_arm[0] = 0; m_arm[1] = 0; m_hit = 0; m_npass = 0;
            return;
        end
        flush = 0;
        case (m_state)
            0: if (start) begin m_state = 1; m_score = 0; flush = 1; end
            1: begin
                if (!start || m_hit) begin
                    m_state = start ? 2 : 0;
                    if (m_score > m_high) m_high = m_score;
                end else begin
                    m_score = (m_score + m_npass > 9999) ? 9999 : m_score + m_npass;
                end
            end
            default: if (!start) m_state = 0;
        endcase
        hit = (b == 0) || (b + 20 >= 480);
        np  = 0;
        for (int p = 0; p < 2; p++) begin
            if (xs[p] < 120 && xs[p] + 50 > 100 && !(b >= ys[p] && b + 20 <= ys[p] + 120))
                hit = 1;
            if (m_arm[p] && xs[p] + 50 <= 100) begin
                np++;
                m_arm[p] = 0;
            end else if (xs[p] >= 120) begin
                m_arm[p] = 1;
            end
        end
        m_hit   = flush ? 1'b0 : hit;
        m_npass = flush ? 0 : np;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_lost", int'(lost), (m_state == 2) ? 1 : 0);
        chk("model_playing", int'(playing), (m_state == 1) ? 1 : 0);
        chk("model_score", bcd2int(score), m_score);
        chk("model_high", bcd2int(high), m_high);
    endtask

    task automatic park_and_play();
        rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b1; by = 10'd200;
        xa = 10'd1023; ya = 10'd150; xb = 10'd1023; yb = 10'd150;
        tick();
        tick();
    endtask

    typedef struct {
        int by;
        int xa;
        int ya;
        int xb;
        int yb;
        int exp_lost;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int step;
        int nx;

        vecs[0]  = '{100, 120, 150, 1023, 150, 0};   // just right of bird: no overlap
        vecs[1]  = '{100, 119, 150, 1023, 150, 1};   // first overlapping column, above gap
        vecs[2]  = '{150, 110, 150, 1023, 150, 0};   // top flush with gap top
        vecs[3]  = '{251, 110, 150, 1023, 150, 1};   // bottom 271 past gap end 270
        vecs[4]  = '{250, 110, 150, 1023, 150, 0};   // bottom exactly at gap end
        vecs[5]  = '{0,   1023, 150, 1023, 150, 1};  // ceiling
        vecs[6]  = '{460, 1023, 150, 1023, 150, 1};  // floor
        vecs[7]  = '{459, 1023, 150, 1023, 150, 0};
        vecs[8]  = '{200, 51,  300, 1023, 150, 1};   // last overlapping column on the left
        vecs[9]  = '{200, 50,  300, 1023, 150, 0};   // pipe right edge meets bird left edge
        vecs[10] = '{100, 1023, 150, 119, 150, 1};   // pipe B collision
        vecs[11] = '{100, 1000, 950, 1023, 150, 0};  // large X/Y must not wrap

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset_lost", int'(lost), 0);
        chk("reset_score", bcd2int(score), 0);

        // Sweep pipe A across the bird twice
        rst = 1'b0; start = 1'b1; by = 10'd200; ya = 10'd150; xb = 10'd1023; yb = 10'd150;
        for (int x = 1023; x >= 0; x--) begin
            xa = 10'(x);
            tick();
            if (x == 50) chk("sweep1_before", bcd2int(score), 0);
            if (x == 49) chk("sweep1_count", bcd2int(score), 1);
        end
        for (int x = 1000; x >= 40; x--) begin
            xa = 10'(x);
            tick();
        end
        chk("sweep2_count", bcd2int(score), 2);
        chk("sweep_never_lost", int'(lost), 0);

        // Pipe hit: Lost two clocks later, score frozen
        by = 10'd100; xa = 10'd110;
        tick();
        chk("hit_lat1_lost", int'(lost), 0);
        tick();
        chk("hit_lost", int'(lost), 1);
        chk("hit_playing", int'(playing), 0);
        chk("hit_score", bcd2int(score), 2);
        chk("hit_high", bcd2int(high), 2);
        start = 1'b0;
        tick();
        chk("dead_to_idle", int'(lost), 0);

        // Geometry table
        for (int i = 0; i < 12; i++) begin
            park_and_play();
            by = 10'(vecs[i].by); xa = 10'(vecs[i].xa); ya = 10'(vecs[i].ya);
            xb = 10'(vecs[i].xb); yb = 10'(vecs[i].yb);
            tick();
            tick();
            chk($sformatf("vec%0d_lost", i), int'(lost), vecs[i].exp_lost);
        end

        // Score one, then simultaneous pass and floor hit: hit wins
        park_and_play();
        xa = 10'd0;
        tick();
        xa = 10'd1023;
        tick();
        chk("one_pass", bcd2int(score), 1);
        xa = 10'd0; by = 10'd460;
        tick();
        tick();
        chk("hitpass_lost", int'(lost), 1);
        chk("hitpass_score", bcd2int(score), 1);
        chk("hitpass_high", bcd2int(high), 1);
        start = 1'b0;
        tick();
        chk("idle_lost", int'(lost), 0);
        chk("idle_high", bcd2int(high), 1);

        // Double passes up to 9998, then saturation
        park_and_play();
        for (int i = 0; i < 4999; i++) begin
            xa = 10'd0; xb = 10'd0;
            tick();
            xa = 10'd1023; xb = 10'd1023;
            tick();
        end
        chk("score_9998", score, 16'h9998);
        for (int i = 0; i < 2; i++) begin
            xa = 10'd0; xb = 10'd0;
            tick();
            xa = 10'd1023; xb = 10'd1023;
            tick();
            chk("score_sat", score, 16'h9999);
        end

        // Reset while dead clears everything including HighScore
        by = 10'd0;
        tick();
        tick();
        chk("ceiling_lost", int'(lost), 1);
        chk("ceiling_high", high, 16'h9999);
        rst = 1'b1;
        tick();
        chk("rst_dead_lost", int'(lost), 0);
        chk("rst_dead_playing", int'(playing), 0);
        chk("rst_dead_score", int'(score), 0);
        chk("rst_dead_high", int'(high), 0);
        rst = 1'b0; start = 1'b0; by = 10'd200;
        tick();
        chk("rst_idle_playing", int'(playing), 0);

        // Random play against the model
        start = 1'b1; xa = 10'd1023; xb = 10'd600;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) start = ~start;
            step = $urandom_range(1, 8);
            nx = int'(xa);
            if (nx < step) begin
                xa = 10'($urandom_range(900, 1023));
                ya = 10'($urandom_range(60, 300));
            end else begin
                xa = 10'(nx - step);
            end
            nx = int'(xb);
            if (nx < step) begin
                xb = 10'($urandom_range(900, 1023));
                yb = 10'($urandom_range(60, 300));
            end else begin
                xb = 10'(nx - step);
            end
            if ($urandom_range(0, 9) == 0) by = 10'($urandom_range(0, 1023));
            else by = 10'(int'(ya) + $urandom_range(0, 100));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
